// File: rtl/adc_rd_pkg.sv
// Shared types and defaults for the ADC serial reader (adc_rd) and its sck generator.
package adc_rd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_SETUP,
    ST_SHIFT,
    ST_QUIET
  } state_t;

  localparam int ADC_DATA_W  = 16;
  localparam int ADC_SCK_DIV = 2;
  localparam int ADC_TCONV   = 8;
  localparam int ADC_TQUIET  = 4;
  localparam int ADC_CNT_W   = 5;

  // Bits needed to hold a count from 0 up to max_val (at least one bit).
  function automatic int cnt_bits(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/adc_rd_sck_gen.sv
// Serial clock generator: half-period divider, sck register and edge strobes for one frame.
// Half 0 is the low setup half; halves 1..2*DATA_W alternate high/low; o_done ends the last half.
module adc_rd_sck_gen
  import adc_rd_pkg::*;
#(
  parameter int DATA_W      = ADC_DATA_W,
  parameter int SCK_DIV     = ADC_SCK_DIV,
  parameter bit SAMPLE_FALL = 1'b0
) (
  input  logic clk,
  input  logic i_clr,
  input  logic i_en,
  output logic o_sck,
  output logic o_rise,
  output logic o_sample,
  output logic o_done
);

  localparam int DIV_W    = cnt_bits(SCK_DIV - 1);
  localparam int HALF_MAX = 2 * DATA_W;
  localparam int HALF_W   = cnt_bits(HALF_MAX);

  logic [DIV_W-1:0]  r_div;
  logic [HALF_W-1:0] r_half;
  logic              r_sck;
  logic              w_tick;
  logic              w_last;
  logic              w_rise;
  logic              w_fall;

  // Strobes mark the clk edge at which sck is about to change.
  assign w_tick = i_en && (r_div == DIV_W'(SCK_DIV - 1));
  assign w_last = (r_half == HALF_W'(HALF_MAX));
  assign w_rise = w_tick && !w_last && !r_sck;
  assign w_fall = w_tick && !w_last && r_sck;

  assign o_sck    = r_sck;
  assign o_rise   = w_rise;
  assign o_sample = SAMPLE_FALL ? w_fall : w_rise;
  assign o_done   = w_tick && w_last;

  always_ff @(posedge clk) begin
    if (i_clr || !i_en) begin
      r_div  <= '0;
      r_half <= '0;
      r_sck  <= 1'b0;
    end else if (w_tick) begin
      r_div <= '0;
      if (!w_last) begin
        r_half <= r_half + 1'b1;
        r_sck  <= ~r_sck;
      end
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

endmodule

// File: rtl/adc_rd.sv
// SPI-style ADC reader: start -> conversion wait -> DATA_W-bit MSB-first read -> quiet gap.
// Define ADC_SAMPLE_FALL_EN to sample sdo on sck falling edges instead of rising edges.
module adc_rd
  import adc_rd_pkg::*;
#(
  parameter int DATA_W  = ADC_DATA_W,
  parameter int SCK_DIV = ADC_SCK_DIV,
  parameter int TCONV   = ADC_TCONV,
  parameter int TQUIET  = ADC_TQUIET
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 key_state,
  input  logic                 start,
  input  logic                 sdo,
  output logic                 cs,
  output logic                 sck,
  output logic [ADC_CNT_W-1:0] cnt_sck,
  output logic [DATA_W-1:0]    data_out,
  output logic                 data_valid,
  output logic                 busy
);

`ifdef ADC_SAMPLE_FALL_EN
  localparam bit SAMPLE_FALL = 1'b1;
`else
  localparam bit SAMPLE_FALL = 1'b0;
`endif

  localparam int TMR_MAX = ((TCONV > TQUIET) ? TCONV : TQUIET) - 1;
  localparam int TMR_W   = cnt_bits(TMR_MAX);

  state_t               r_state;
  logic [TMR_W-1:0]     r_tmr;
  logic [DATA_W-1:0]    r_shreg;
  logic [ADC_CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0]    r_dout;
  logic                 r_cs;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_fin;

  logic w_clr;
  logic w_en;
  logic w_sck;
  logic w_rise;
  logic w_sample;
  logic w_done;

  assign w_clr = rst || !key_state;
  assign w_en  = ((r_state == ST_SETUP) || (r_state == ST_SHIFT)) && !r_fin;

  adc_rd_sck_gen #(
    .DATA_W      (DATA_W),
    .SCK_DIV     (SCK_DIV),
    .SAMPLE_FALL (SAMPLE_FALL)
  ) u_sck_gen (
    .clk      (clk),
    .i_clr    (w_clr),
    .i_en     (w_en),
    .o_sck    (w_sck),
    .o_rise   (w_rise),
    .o_sample (w_sample),
    .o_done   (w_done)
  );

  // NOTE: every state bit, including the shift register, is cleared by the reset branch;
  // it is a flop vector, not a RAM, so the clear costs nothing and keeps aborted frames clean.
  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_cs    <= 1'b1;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_fin   <= 1'b0;
    end else begin
      r_valid <= 1'b0;

      if (w_sample) begin
        r_shreg <= {r_shreg[DATA_W-2:0], sdo};
        if (r_cnt != ADC_CNT_W'(DATA_W)) r_cnt <= r_cnt + 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_CONV;
            r_busy  <= 1'b1;
            r_tmr   <= '0;
          end
        end
        ST_CONV: begin
          if (r_tmr == TMR_W'(TCONV - 1)) begin
            r_tmr   <= '0;
            r_state <= ST_SETUP;
            r_cs    <= 1'b0;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        ST_SETUP: begin
          if (w_rise) r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          // One hold cycle after the last low half, then the word is published.
          if (w_done) r_fin <= 1'b1;
          if (r_fin) begin
            r_fin   <= 1'b0;
            r_state <= ST_QUIET;
            r_cs    <= 1'b1;
            r_dout  <= r_shreg;
            r_valid <= 1'b1;
          end
        end
        ST_QUIET: begin
          if (r_tmr == TMR_W'(TQUIET - 1)) begin
            r_tmr   <= '0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cs         = r_cs;
  assign sck        = w_sck;
  assign cnt_sck    = r_cnt;
  assign data_out   = r_dout;
  assign data_valid = r_valid;
  assign busy       = r_busy;

endmodule

// File: tb/tb_adc_rd.sv
// Directed bench for adc_rd with a behavioural ADC and a latency-tagged scoreboard.
module tb_adc_rd;

  localparam int DW     = 16;
  localparam int TCONV  = 8;
  localparam int TQUIET = 4;
  localparam int LAT    = 76;              // 2 + TCONV + (2*DW+1)*SCK_DIV
  localparam int CS_LOW = LAT - 1 - TCONV; // SETUP + SHIFT cycles with cs low

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          key_state = 1'b1;
  logic          start = 1'b0;
  logic          sdo = 1'b0;
  logic          cs;
  logic          sck;
  logic [4:0]    cnt_sck;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          busy;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            n_rise = 0;
  int            n_cs_low = 0;
  int            fall_cyc = 0;
  int            rise_cyc = 0;
  logic          prev_cs = 1'b1;
  logic [DW-1:0] model_word = '0;
  exp_t          sb_q[$];

  adc_rd dut (
    .clk        (clk),
    .rst        (rst),
    .key_state  (key_state),
    .start      (start),
    .sdo        (sdo),
    .cs         (cs),
    .sck        (sck),
    .cnt_sck    (cnt_sck),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;
  always @(posedge sck) n_rise++;

  always @(negedge clk) begin
    if (!cs) n_cs_low++;
    if (prev_cs && !cs) fall_cyc = cyc;
    if (!prev_cs && cs) rise_cyc = cyc;
    prev_cs = cs;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ADC model: presents the word MSB first; data moves on the edge opposite to sampling.
  initial begin
    int idx;
    forever begin
      @(negedge cs);
`ifdef ADC_SAMPLE_FALL_EN
      idx = DW;
      while (idx > 0 && !cs) begin
        @(posedge sck or posedge cs);
        if (!cs) begin
          idx--;
          sdo = model_word[idx];
        end
      end
`else
      idx = DW - 1;
      sdo = model_word[idx];
      while (idx > 0 && !cs) begin
        @(negedge sck or posedge cs);
        if (!cs) begin
          idx--;
          sdo = model_word[idx];
        end
      end
`endif
    end
  end

  // Scoreboard: every data_valid must match the oldest expectation in data and cycle.
  always @(negedge clk) begin
    if (data_valid) begin
      check("valid_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("data_out", 32'(data_out), 32'(e.data));
        check("latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_start(input logic [DW-1:0] word);
    exp_t e;
    model_word = word;
    e.data = word;
    e.cyc  = cyc + LAT;
    sb_q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stray_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int t0;
    int r0;
    int c0;
    int rise1;
    int budget;
    logic [DW-1:0] w1;

`ifdef ADC_SAMPLE_FALL_EN
    w1 = 16'h5A5A;
`else
    w1 = 16'hA5C3;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_cnt", 32'(cnt_sck), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame
    t0 = cyc; r0 = n_rise; c0 = n_cs_low;
    do_start(w1);
    wait_until(t0 + 9);
    check("cs_low_setup", 32'(cs), 32'd0);
    wait_until(t0 + LAT);
    check("cnt_sck_full", 32'(cnt_sck), 32'(DW));
    check("cs_high_quiet", 32'(cs), 32'd1);
    wait_until(t0 + LAT + 5);
    check("sck_rises", 32'(n_rise - r0), 32'(DW));
    check("cs_low_cycles", 32'(n_cs_low - c0), 32'(CS_LOW));
    check("sb_empty_1", 32'(sb_q.size()), 32'd0);
    check("cnt_sck_idle", 32'(cnt_sck), 32'd0);

    // Stray starts during a frame are ignored
    t0 = cyc;
    do_start(16'h3C96);
    wait_until(t0 + 10);
    stray_start();
    wait_until(t0 + 40);
    stray_start();
    check("busy_mid", 32'(busy), 32'd1);
    wait_until(t0 + LAT + TQUIET - 1);
    check("busy_quiet_end", 32'(busy), 32'd1);
    wait_until(t0 + LAT + TQUIET);
    check("busy_idle", 32'(busy), 32'd0);
    wait_until(t0 + 2 * LAT);
    check("sb_empty_2", 32'(sb_q.size()), 32'd0);
    check("data_hold", 32'(data_out), 32'h3C96);

    // Reset mid-SHIFT at cnt_sck = 7
    do_start(16'h0F0F);
    budget = 200;
    while (cnt_sck != 5'd7 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("reach_cnt7", 32'(budget > 0), 32'd1);
    rst = 1'b1;
    void'(sb_q.pop_back());
    @(negedge clk);
    check("abort_cs", 32'(cs), 32'd1);
    check("abort_sck", 32'(sck), 32'd0);
    check("abort_cnt", 32'(cnt_sck), 32'd0);
    check("abort_data", 32'(data_out), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (LAT) @(negedge clk);
    t0 = cyc;
    do_start(16'h1234);
    wait_until(t0 + LAT + 5);
    check("sb_empty_3", 32'(sb_q.size()), 32'd0);
    check("data_1234", 32'(data_out), 32'h1234);

    // key_state dropped mid-CONV, then start while disabled
    t0 = cyc;
    do_start(16'hBEEF);
    wait_until(t0 + 4);
    key_state = 1'b0;
    void'(sb_q.pop_back());
    @(negedge clk);
    check("key_busy", 32'(busy), 32'd0);
    check("key_cs", 32'(cs), 32'd1);
    check("key_data", 32'(data_out), 32'd0);
    c0 = n_cs_low;
    stray_start();
    repeat (20) @(negedge clk);
    check("key_idle_busy", 32'(busy), 32'd0);
    check("key_no_cs", 32'(n_cs_low - c0), 32'd0);
    key_state = 1'b1;
    repeat (3) @(negedge clk);

    // Back-to-back frames
    t0 = cyc;
    do_start(16'hFFFF);
    wait_until(t0 + LAT + TQUIET);
    check("b2b_first_idle", 32'(busy), 32'd0);
    rise1 = rise_cyc;
    do_start(16'h0001);
    wait_until(t0 + 2 * LAT + TQUIET + 5);
    check("sb_empty_5", 32'(sb_q.size()), 32'd0);
    check("data_0001", 32'(data_out), 32'h0001);
    check("cs_gap", 32'((fall_cyc - rise1) >= (TQUIET + TCONV)), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
